// File: rtl/fpu_pkg.sv
// Shared definitions for the sequential single-precision adder.
// Holds the FSM state encoding, IEEE-754 field widths, the canonical quiet NaN,
// flag bit positions inside flags_o, and a small helper that builds a signed Inf.
package fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_DONE  = 3'd4
    } add_state_e;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam int          FRAC_W  = 23;
    localparam int          EXP_W   = 8;

    // Bit positions inside flags_o = {invalid, overflow, underflow, inexact}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    // Signed infinity with the given sign bit
    function automatic logic [31:0] pack_inf(input logic sign);
        return {sign, EXP_MAX, {FRAC_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fpu_add_seq_operands.sv
// Operand decomposition for the adder sequencer (purely combinational).
// Splits X and Y into sign/exponent/fraction, applies the subtract request to
// Y's sign, classifies Inf/NaN and compares magnitudes.
// Ports:
//   x_i, y_i      packed single-precision operands
//   sub_i         1 = X-Y (flips Y's effective sign)
//   x/y_sign_o    signs (Y already effective)
//   x/y_exp_o     biased exponents
//   x/y_frac_o    stored fractions
//   x_greater_o   |X| > |Y| strictly (equal magnitudes report 0, i.e. Y wins)
//   exp_shift_o   |ex - ey|
//   x/y_inf_o, x/y_nan_o  class flags
module fpu_add_seq_operands
    import fpu_pkg::*;
(
    input  logic [31:0]       x_i,
    input  logic [31:0]       y_i,
    input  logic              sub_i,
    output logic              x_sign_o,
    output logic              y_sign_o,
    output logic [EXP_W-1:0]  x_exp_o,
    output logic [EXP_W-1:0]  y_exp_o,
    output logic [FRAC_W-1:0] x_frac_o,
    output logic [FRAC_W-1:0] y_frac_o,
    output logic              x_greater_o,
    output logic [EXP_W-1:0]  exp_shift_o,
    output logic              x_inf_o,
    output logic              y_inf_o,
    output logic              x_nan_o,
    output logic              y_nan_o
);

    logic [EXP_W-1:0]  x_exp_s;
    logic [EXP_W-1:0]  y_exp_s;
    logic [FRAC_W-1:0] x_frac_s;
    logic [FRAC_W-1:0] y_frac_s;
    logic              x_greater_s;

    assign x_exp_s  = x_i[30:23];
    assign y_exp_s  = y_i[30:23];
    assign x_frac_s = x_i[22:0];
    assign y_frac_s = y_i[22:0];

    // Exponent and fraction are contiguous, so an unsigned compare of the low
    // 31 bits is a magnitude compare.
    assign x_greater_s = (x_i[30:0] > y_i[30:0]);

    assign x_sign_o    = x_i[31];
    assign y_sign_o    = y_i[31] ^ sub_i;
    assign x_exp_o     = x_exp_s;
    assign y_exp_o     = y_exp_s;
    assign x_frac_o    = x_frac_s;
    assign y_frac_o    = y_frac_s;
    assign x_greater_o = x_greater_s;

    // The larger-magnitude operand never has the smaller exponent, so this
    // difference never wraps.
    assign exp_shift_o = x_greater_s ? (x_exp_s - y_exp_s) : (y_exp_s - x_exp_s);

    assign x_inf_o = (x_exp_s == EXP_MAX) && (x_frac_s == {FRAC_W{1'b0}});
    assign y_inf_o = (y_exp_s == EXP_MAX) && (y_frac_s == {FRAC_W{1'b0}});
    assign x_nan_o = (x_exp_s == EXP_MAX) && (x_frac_s != {FRAC_W{1'b0}});
    assign y_nan_o = (y_exp_s == EXP_MAX) && (y_frac_s != {FRAC_W{1'b0}});

endmodule

// File: rtl/fpu_add_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract, round toward zero,
// denormals flushed to zero. One operation in flight.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   in_valid_i / in_ready_o    request handshake (ready only in IDLE)
//   x_i, y_i, sub_i            operands, 1 = X-Y
//   out_valid_o / out_ready_i  result handshake (valid only in DONE)
//   result_o                   packed result, held until accepted
//   flags_o                    {invalid, overflow, underflow, inexact}
module fpu_add_seq
    import fpu_pkg::*;
#(
    parameter int unsigned ALIGN_CLAMP = 25
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    input  logic        sub_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic [3:0]  flags_o
);

    localparam logic [7:0] CLAMP8 = ALIGN_CLAMP[7:0];

    // Decomposed operands
    logic              x_sign_s, y_sign_s;
    logic [EXP_W-1:0]  x_exp_s, y_exp_s;
    logic [FRAC_W-1:0] x_frac_s, y_frac_s;
    logic              x_greater_s;
    logic [EXP_W-1:0]  exp_shift_s;
    logic              x_inf_s, y_inf_s, x_nan_s, y_nan_s;

    // State and datapath registers
    add_state_e  state_r, state_nxt_s;
    logic [24:0] big_r, big_nxt_s;
    logic [24:0] small_r, small_nxt_s;
    logic [24:0] sum_r, sum_nxt_s;
    logic        sticky_r, sticky_nxt_s;
    logic [4:0]  cnt_r, cnt_nxt_s;
    logic [8:0]  res_exp_r, res_exp_nxt_s;
    logic        res_sign_r, res_sign_nxt_s;
    logic        eff_sub_r, eff_sub_nxt_s;
    logic [31:0] result_r, result_nxt_s;
    logic [3:0]  flags_r, flags_nxt_s;
    logic        in_ready_r;
    logic        out_valid_r;

    // Helper values
    logic [24:0] x_man_s, y_man_s;
    logic [4:0]  cnt_load_s;
    logic [8:0]  exp_inc_s, exp_dec_s;

    // The decision to take a special-case shortcut is made on the accepting
    // edge itself, so the decomposition sees the operands being accepted.
    fpu_add_seq_operands u_operands (
        .x_i         (x_i),
        .y_i         (y_i),
        .sub_i       (sub_i),
        .x_sign_o    (x_sign_s),
        .y_sign_o    (y_sign_s),
        .x_exp_o     (x_exp_s),
        .y_exp_o     (y_exp_s),
        .x_frac_o    (x_frac_s),
        .y_frac_o    (y_frac_s),
        .x_greater_o (x_greater_s),
        .exp_shift_o (exp_shift_s),
        .x_inf_o     (x_inf_s),
        .y_inf_o     (y_inf_s),
        .x_nan_o     (x_nan_s),
        .y_nan_o     (y_nan_s)
    );

    // Mantissas carry a guard zero above the hidden bit; exp==0 flushes to zero.
    assign x_man_s    = (x_exp_s != 8'd0) ? {2'b01, x_frac_s} : 25'd0;
    assign y_man_s    = (y_exp_s != 8'd0) ? {2'b01, y_frac_s} : 25'd0;
    assign cnt_load_s = (exp_shift_s > CLAMP8) ? CLAMP8[4:0] : exp_shift_s[4:0];
    assign exp_inc_s  = res_exp_r + 9'd1;
    assign exp_dec_s  = res_exp_r - 9'd1;

    // Next-state and datapath update logic
    always_comb begin
        state_nxt_s    = state_r;
        big_nxt_s      = big_r;
        small_nxt_s    = small_r;
        sum_nxt_s      = sum_r;
        sticky_nxt_s   = sticky_r;
        cnt_nxt_s      = cnt_r;
        res_exp_nxt_s  = res_exp_r;
        res_sign_nxt_s = res_sign_r;
        eff_sub_nxt_s  = eff_sub_r;
        result_nxt_s   = result_r;
        flags_nxt_s    = flags_r;

        case (state_r)
            ST_IDLE: begin
                if (in_valid_i) begin
                    if (x_nan_s || y_nan_s) begin
                        result_nxt_s              = QNAN;
                        flags_nxt_s               = 4'b0000;
                        flags_nxt_s[FLAG_INVALID] = 1'b1;
                        state_nxt_s               = ST_DONE;
                    end else if (x_inf_s && y_inf_s && (x_sign_s != y_sign_s)) begin
                        result_nxt_s              = QNAN;
                        flags_nxt_s               = 4'b0000;
                        flags_nxt_s[FLAG_INVALID] = 1'b1;
                        state_nxt_s               = ST_DONE;
                    end else if (x_inf_s) begin
                        result_nxt_s = pack_inf(x_sign_s);
                        flags_nxt_s  = 4'b0000;
                        state_nxt_s  = ST_DONE;
                    end else if (y_inf_s) begin
                        result_nxt_s = pack_inf(y_sign_s);
                        flags_nxt_s  = 4'b0000;
                        state_nxt_s  = ST_DONE;
                    end else begin
                        // Ties go to Y so an exact cancellation keeps Y's sign path.
                        if (x_greater_s) begin
                            big_nxt_s      = x_man_s;
                            small_nxt_s    = y_man_s;
                            res_exp_nxt_s  = {1'b0, x_exp_s};
                            res_sign_nxt_s = x_sign_s;
                        end else begin
                            big_nxt_s      = y_man_s;
                            small_nxt_s    = x_man_s;
                            res_exp_nxt_s  = {1'b0, y_exp_s};
                            res_sign_nxt_s = y_sign_s;
                        end
                        eff_sub_nxt_s = x_sign_s ^ y_sign_s;
                        cnt_nxt_s     = cnt_load_s;
                        sticky_nxt_s  = 1'b0;
                        state_nxt_s   = ST_ALIGN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_ALIGN: begin
                if (cnt_r != 5'd0) begin
                    small_nxt_s  = {1'b0, small_r[24:1]};
                    sticky_nxt_s = sticky_r | small_r[0];
                    cnt_nxt_s    = cnt_r - 5'd1;
                end else begin
                    state_nxt_s = ST_ADD;
                end
            end

            ST_ADD: begin
                // big >= small in magnitude, so the difference never goes negative
                if (eff_sub_r) begin
                    sum_nxt_s = big_r - small_r;
                end else begin
                    sum_nxt_s = big_r + small_r;
                end
                state_nxt_s = ST_NORM;
            end

            ST_NORM: begin
                if (sum_r == 25'd0) begin
                    result_nxt_s              = 32'h0000_0000;
                    flags_nxt_s               = 4'b0000;
                    flags_nxt_s[FLAG_INEXACT] = sticky_r;
                    state_nxt_s               = ST_DONE;
                end else if (sum_r[24]) begin
                    sum_nxt_s     = {1'b0, sum_r[24:1]};
                    sticky_nxt_s  = sticky_r | sum_r[0];
                    res_exp_nxt_s = exp_inc_s;
                    if (exp_inc_s >= 9'd255) begin
                        result_nxt_s               = pack_inf(res_sign_r);
                        flags_nxt_s                = 4'b0000;
                        flags_nxt_s[FLAG_OVERFLOW] = 1'b1;
                        flags_nxt_s[FLAG_INEXACT]  = 1'b1;
                        state_nxt_s                = ST_DONE;
                    end else begin
                        state_nxt_s = ST_NORM;
                    end
                end else if (!sum_r[23]) begin
                    sum_nxt_s     = {sum_r[23:0], 1'b0};
                    res_exp_nxt_s = exp_dec_s;
                    // bit 8 catches a wrap below zero
                    if ((exp_dec_s == 9'd0) || exp_dec_s[8]) begin
                        result_nxt_s                = {res_sign_r, 31'd0};
                        flags_nxt_s                 = 4'b0000;
                        flags_nxt_s[FLAG_UNDERFLOW] = 1'b1;
                        flags_nxt_s[FLAG_INEXACT]   = 1'b1;
                        state_nxt_s                 = ST_DONE;
                    end else begin
                        state_nxt_s = ST_NORM;
                    end
                end else begin
                    result_nxt_s              = {res_sign_r, res_exp_r[7:0], sum_r[22:0]};
                    flags_nxt_s               = 4'b0000;
                    flags_nxt_s[FLAG_INEXACT] = sticky_r;
                    state_nxt_s               = ST_DONE;
                end
            end

            ST_DONE: begin
                if (out_ready_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end

            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake/result outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            big_r       <= 25'd0;
            small_r     <= 25'd0;
            sum_r       <= 25'd0;
            sticky_r    <= 1'b0;
            cnt_r       <= 5'd0;
            res_exp_r   <= 9'd0;
            res_sign_r  <= 1'b0;
            eff_sub_r   <= 1'b0;
            result_r    <= 32'd0;
            flags_r     <= 4'd0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            big_r       <= big_nxt_s;
            small_r     <= small_nxt_s;
            sum_r       <= sum_nxt_s;
            sticky_r    <= sticky_nxt_s;
            cnt_r       <= cnt_nxt_s;
            res_exp_r   <= res_exp_nxt_s;
            res_sign_r  <= res_sign_nxt_s;
            eff_sub_r   <= eff_sub_nxt_s;
            result_r    <= result_nxt_s;
            flags_r     <= flags_nxt_s;
            in_ready_r  <= (state_nxt_s == ST_IDLE);
            out_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_valid_o = out_valid_r;
    assign result_o    = result_r;
    assign flags_o     = flags_r;

endmodule
